// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel edge detector slice.
// Width helpers keep MAG_W/SQ_W tied to whatever DATA_W the top is built with.
package sobel_pkg;

    localparam logic [1:0] MODE_L1  = 2'b00;
    localparam logic [1:0] MODE_MAX = 2'b01;
    localparam logic [1:0] MODE_L2  = 2'b10;

    // MAG_W = DATA_W + 3
    function automatic int mag_width(input int data_w);
        return data_w + 3;
    endfunction

    // SQ_W = 2*DATA_W + 5
    function automatic int sq_width(input int data_w);
        return 2 * data_w + 5;
    endfunction

    typedef struct packed {
        logic vsync;
        logic href;
        logic clken;
    } sync_t;

endpackage

// File: rtl/sobel_edge_detector_cfg_line_buffer.sv
// Two-line shift buffer: line0 holds the previous line, line1 the one before it.
// Reads are combinational so the window can take old data on the same clken that writes.
module sobel_line_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout0,
    output logic [DATA_W-1:0] dout1
);

    logic [DATA_W-1:0] line0 [IMG_W];
    logic [DATA_W-1:0] line1 [IMG_W];
    logic              wr_en;

    assign wr_en = we & ~rst;
    assign dout0 = line0[addr];
    assign dout1 = line1[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line0[addr] <= din;
            line1[addr] <= line0[addr];
        end
    end

endmodule

// File: rtl/sobel_edge_detector_cfg.sv
// 3x3 Sobel edge detector on a vsync/href/clken stream with runtime mode and threshold.
// Output timing is the input timing delayed LAT clocks; border/excess pixels report no edge.
module sobel_edge_detector_cfg
    import sobel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int COL_W  = 10,
    parameter int ROW_W  = 10,
    parameter int LAT    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode,
    input  logic [DATA_W+2:0] cfg_threshold,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_y,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic              post_img_bit,
    output logic [DATA_W+2:0] post_img_mag
);

    localparam int MAG_W = mag_width(DATA_W);
    localparam int SQ_W  = sq_width(DATA_W);
    localparam int SUM_W = DATA_W + 2;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

    function automatic logic [ROW_W-1:0] sat_inc_row(input logic [ROW_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [SUM_W-1:0] wsum(input logic [DATA_W-1:0] a, b, c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] a, b);
        return (a >= b) ? a - b : b - a;
    endfunction

    function automatic logic [2*MAG_W-1:0] square_thr(input logic [MAG_W-1:0] t);
        return (2*MAG_W)'(t) * (2*MAG_W)'(t);
    endfunction

    localparam logic [2*MAG_W-1:0] THR_SQ_RST = square_thr({MAG_W{1'b1}});

    logic              vsync_d, href_d, active;
    logic              vs_rise, href_fall, act_now, pix_en, border_p0;
    logic [COL_W-1:0]  col_cnt;
    logic              col_ovf;
    logic [ROW_W-1:0]  row_cnt;
    logic [1:0]        mode_q;
    logic [MAG_W-1:0]  thr_q;
    logic [2*MAG_W-1:0] thr_sq_q;
    logic [DATA_W-1:0] lb_dout0, lb_dout1;
    logic [DATA_W-1:0] win_p1 [3][3];
    logic              bord_p1, bord_p2, bord_p3, bord_p4;
    logic [SUM_W-1:0]  gxp_p2, gxn_p2, gyp_p2, gyn_p2;
    logic [SUM_W-1:0]  ax_p3, ay_p3;
    logic [MAG_W-1:0]  mag_p4;
    logic [SQ_W-1:0]   sq_p4;
    logic              hit_p4, keep_p4;
    sync_t             sync_in;
    sync_t             sync_p [LAT];

    assign vs_rise   = per_frame_vsync & ~vsync_d;
    assign href_fall = href_d & ~per_frame_href;
    assign act_now   = active | vs_rise;
    assign pix_en    = per_frame_clken & per_frame_href & act_now;
    assign border_p0 = (row_cnt < ROW_W'(2)) || (col_cnt < COL_W'(2)) || col_ovf;

    // Frame control: edge detect, counters and per-frame configuration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d  <= 1'b0;
            href_d   <= 1'b0;
            active   <= 1'b0;
            col_cnt  <= '0;
            col_ovf  <= 1'b0;
            row_cnt  <= '0;
            mode_q   <= MODE_L1;
            thr_q    <= '1;
            thr_sq_q <= THR_SQ_RST;
        end else begin
            vsync_d <= per_frame_vsync;
            href_d  <= per_frame_href;
            if (vs_rise) begin
                active   <= 1'b1;
                mode_q   <= cfg_mode;
                thr_q    <= cfg_threshold;
                thr_sq_q <= square_thr(cfg_threshold);
                col_cnt  <= '0;
                col_ovf  <= 1'b0;
                row_cnt  <= '0;
            end else if (href_fall) begin
                col_cnt <= '0;
                col_ovf <= 1'b0;
                row_cnt <= sat_inc_row(row_cnt);
            end else if (pix_en) begin
                if (col_cnt == COL_LAST) col_ovf <= 1'b1;
                else                     col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    sobel_line_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .ADDR_W (COL_W)
    ) u_line_buffer (
        .clk   (clk),
        .rst   (rst),
        .we    (pix_en & ~col_ovf),
        .addr  (col_cnt),
        .din   (per_img_y),
        .dout0 (lb_dout0),
        .dout1 (lb_dout1)
    );

    // S1: 3x3 window, advanced only on accepted pixels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_p1[r][c] <= '0;
            bord_p1 <= 1'b1;
        end else if (pix_en) begin
            for (int r = 0; r < 3; r++) begin
                win_p1[r][0] <= win_p1[r][1];
                win_p1[r][1] <= win_p1[r][2];
            end
            win_p1[0][2] <= lb_dout1;
            win_p1[1][2] <= lb_dout0;
            win_p1[2][2] <= per_img_y;
            bord_p1      <= border_p0;
        end
    end

    // S2..S4: free-running arithmetic on the held window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gxp_p2 <= '0; gxn_p2 <= '0; gyp_p2 <= '0; gyn_p2 <= '0;
            ax_p3  <= '0; ay_p3  <= '0;
            mag_p4 <= '0; sq_p4  <= '0;
            bord_p2 <= 1'b1; bord_p3 <= 1'b1; bord_p4 <= 1'b1;
        end else begin
            gxp_p2  <= wsum(win_p1[0][2], win_p1[1][2], win_p1[2][2]);
            gxn_p2  <= wsum(win_p1[0][0], win_p1[1][0], win_p1[2][0]);
            gyp_p2  <= wsum(win_p1[0][0], win_p1[0][1], win_p1[0][2]);
            gyn_p2  <= wsum(win_p1[2][0], win_p1[2][1], win_p1[2][2]);
            bord_p2 <= bord_p1;

            ax_p3   <= abs_diff(gxp_p2, gxn_p2);
            ay_p3   <= abs_diff(gyp_p2, gyn_p2);
            bord_p3 <= bord_p2;

            case (mode_q)
                MODE_MAX: mag_p4 <= MAG_W'((ax_p3 >= ay_p3) ? ax_p3 : ay_p3);
                default:  mag_p4 <= MAG_W'(ax_p3) + MAG_W'(ay_p3);
            endcase
            sq_p4   <= SQ_W'(ax_p3) * SQ_W'(ax_p3) + SQ_W'(ay_p3) * SQ_W'(ay_p3);
            bord_p4 <= bord_p3;
        end
    end

    always_comb begin
        hit_p4 = mag_p4 >= thr_q;
        if (mode_q == MODE_L2) hit_p4 = {1'b0, sq_p4} >= thr_sq_q;
        sync_in = '0;
        if (act_now) sync_in = '{vsync: per_frame_vsync, href: per_frame_href, clken: per_frame_clken};
    end

    assign keep_p4 = sync_p[LAT-2].href & ~bord_p4;

    // S5: threshold, output register and timing delay line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) sync_p[i] <= '0;
            post_img_bit <= 1'b0;
            post_img_mag <= '0;
        end else begin
            sync_p[0] <= sync_in;
            for (int i = 1; i < LAT; i++) sync_p[i] <= sync_p[i-1];
            post_img_bit <= keep_p4 & hit_p4;
            post_img_mag <= keep_p4 ? mag_p4 : '0;
        end
    end

    assign post_frame_vsync = sync_p[LAT-1].vsync;
    assign post_frame_href  = sync_p[LAT-1].href;
    assign post_frame_clken = sync_p[LAT-1].clken;

endmodule

// File: tb/tb_sobel_edge_detector_cfg.sv
// Bench for sobel_edge_detector_cfg: directed and random frames against an arithmetic Sobel model.
module tb_sobel_edge_detector_cfg;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 20;
    localparam int COL_W  = 5;
    localparam int ROW_W  = 10;
    localparam int LAT    = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        cfg_mode = 2'b00;
    logic [DATA_W+2:0] cfg_threshold = '0;
    logic              per_frame_vsync = 1'b0;
    logic              per_frame_href = 1'b0;
    logic              per_frame_clken = 1'b0;
    logic [DATA_W-1:0] per_img_y = '0;
    logic              post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit;
    logic [DATA_W+2:0] post_img_mag;

    sobel_edge_detector_cfg #(
        .DATA_W (DATA_W), .IMG_W (IMG_W), .COL_W (COL_W), .ROW_W (ROW_W), .LAT (LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_mode         (cfg_mode),
        .cfg_threshold    (cfg_threshold),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_y        (per_img_y),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_bit     (post_img_bit),
        .post_img_mag     (post_img_mag)
    );

    always #5 clk = ~clk;

    typedef struct { int b; int mag; } exp_t;

    exp_t       exp_q[$];
    logic [2:0] hist [0:65535];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         ones = 0;
    bit         frame_live = 1'b0;
    int         fr_mode = 0;
    int         fr_thr = 0;
    int         img [0:15][0:31];

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Timing reference: what the input stream looked like at each sampling edge
    always @(posedge clk) begin
        hist[16'(cyc)] = frame_live ? {per_frame_vsync, per_frame_href, per_frame_clken} : 3'b000;
        cyc++;
    end

    always @(negedge clk) begin
        logic [2:0] want_t;
        exp_t       e;
        want_t = (cyc >= 5) ? hist[16'(cyc - 5)] : 3'b000;
        check("post_vsync", int'(post_frame_vsync), int'(want_t[2]));
        check("post_href",  int'(post_frame_href),  int'(want_t[1]));
        check("post_clken", int'(post_frame_clken), int'(want_t[0]));
        if (post_frame_clken && post_frame_href) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pixel", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("edge_bit", int'(post_img_bit), e.b);
                check("edge_mag", int'(post_img_mag), e.mag);
                if (post_img_bit) ones++;
            end
        end else if (!post_frame_href) begin
            check("idle_bit", int'(post_img_bit), 0);
            check("idle_mag", int'(post_img_mag), 0);
        end
    end

    function automatic int pat_pix(input int pat, input int r, input int c);
        case (pat)
            0:       return 100;
            1:       return (c >= 8) ? 255 : 0;
            2:       return (r == 4 && c == 4) ? 255 : 0;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // Output at input (r,c) describes the centre pixel (r-1,c-1)
    function automatic void push_model(input int r, input int c);
        int   gx, gy, ax, ay, l1, mx;
        exp_t e;
        e.b = 0;
        e.mag = 0;
        if (r >= 2 && c >= 2 && c < IMG_W) begin
            gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
               - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
            gy = (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c])
               - (img[r][c-2] + 2*img[r][c-1] + img[r][c]);
            ax = (gx < 0) ? -gx : gx;
            ay = (gy < 0) ? -gy : gy;
            l1 = ax + ay;
            mx = (ax > ay) ? ax : ay;
            case (fr_mode)
                1: begin e.mag = mx; e.b = (mx >= fr_thr) ? 1 : 0; end
                2: begin e.mag = l1; e.b = (gx*gx + gy*gy >= fr_thr*fr_thr) ? 1 : 0; end
                default: begin e.mag = l1; e.b = (l1 >= fr_thr) ? 1 : 0; end
            endcase
        end
        exp_q.push_back(e);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        frame_live = 1'b0;
        exp_q.delete();
        for (int k = cyc - 5; k < cyc; k++)
            if (k >= 0) hist[16'(k)] = 3'b000;
        #2;
        check("rst_mid_clken", int'(post_frame_clken), 0);
        check("rst_mid_mag", int'(post_img_mag), 0);
        tick();
        rst = 1'b0;
    endtask

    // mode/thr < 0 leave the config inputs untouched; thr_mid >= 0 changes the threshold mid-frame
    task automatic run_frame(input int rows, input int cols, input int pat, input int mode,
                             input int thr, input int thr_mid, input bit gaps, input int rst_row);
        int pix, n;
        if (mode >= 0) cfg_mode = 2'(mode);
        if (thr >= 0)  cfg_threshold = 11'(thr);
        fr_mode = int'(cfg_mode);
        fr_thr  = int'(cfg_threshold);
        ones = 0;
        frame_live = 1'b1;
        per_frame_vsync = 1'b1;
        tick(); tick();
        per_frame_vsync = 1'b0;
        repeat (3) tick();
        for (int r = 0; r < rows; r++) begin
            if (r == 3 && thr_mid >= 0) cfg_threshold = 11'(thr_mid);
            per_frame_href = 1'b1;
            for (int c = 0; c < cols; c++) begin
                n = (gaps && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
                per_frame_clken = 1'b0;
                repeat (n) tick();
                if (r == rst_row && c == cols / 2) do_reset();
                pix = pat_pix(pat, r, c);
                img[r][c] = pix;
                per_img_y = 8'(pix);
                per_frame_clken = 1'b1;
                if (frame_live) push_model(r, c);
                tick();
            end
            per_frame_clken = 1'b0;
            per_frame_href = 1'b0;
            repeat (4) tick();
        end
        repeat (8) tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        repeat (3) tick();
        check("rst_bit", int'(post_img_bit), 0);
        check("rst_mag", int'(post_img_mag), 0);
        check("rst_href", int'(post_frame_href), 0);
        rst = 1'b0;
        tick();

        run_frame(8, 16, 0, 0, 1, -1, 1'b0, -1);
        check("flat_edges", ones, 0);
        run_frame(8, 16, 1, 0, 500, -1, 1'b0, -1);
        check("step_l1_edges", ones, 12);
        run_frame(8, 16, 1, 2, 1000, -1, 1'b0, -1);
        check("step_l2_edges", ones, 12);
        run_frame(8, 16, 1, 2, 1021, -1, 1'b0, -1);
        check("step_l2_hi_edges", ones, 0);
        run_frame(8, 16, 2, 1, 510, -1, 1'b0, -1);
        check("diag_max_edges", ones, 4);
        run_frame(8, 16, 2, 0, 510, -1, 1'b1, -1);
        run_frame(8, 16, 3, 3, 300, 5, 1'b1, -1);
        run_frame(8, 16, 3, -1, -1, -1, 1'b1, -1);
        run_frame(6, IMG_W + 4, 3, 1, 200, -1, 1'b1, -1);
        run_frame(8, 16, 3, 0, 250, -1, 1'b1, 3);
        run_frame(8, 16, 3, 2, 400, -1, 1'b1, -1);
        for (int f = 0; f < 4; f++)
            run_frame(8, 16, 3, int'($urandom_range(0, 3)), int'($urandom_range(50, 900)),
                      -1, 1'b1, -1);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
